// File: rtl/xlatency_probe_pkg.sv
// rtl/xlatency_probe_pkg.sv - shared types and helpers for the latency probe
//
// Purpose : FSM state encoding, default marker token and the saturating
//           pad subtractor used by xlatency_probe. The encoding is kept here
//           so configuration/debug readback can decode the probe state.
// Ports   : none (package)
package xlatency_probe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [31:0] XLP_MARKER_DEFAULT = 32'hA5A5_5A5A;

   // Padding still needed to reach the target; never wraps below zero.
   function automatic logic [31:0] pad_calc(input logic [31:0] target,
                                            input logic [31:0] lat);
      return (target > lat) ? (target - lat) : 32'd0;
   endfunction

endpackage

// File: rtl/xlatency_probe.sv
// rtl/xlatency_probe.sv - datapath latency probe for delay-unit alignment
//
// Purpose : Injects a one-cycle marker word at the input of a path under
//           test, counts cycles until it reappears at the path output and
//           reports the latency plus the padding needed to reach target_lat.
// Ports   : clk        - clock
//           rst        - asynchronous active-high reset
//           run        - start pulse (honoured in IDLE and DONE only)
//           done       - high when idle or result valid
//           probe_out  - drives the path input (marker for one cycle)
//           probe_in   - observes the path output
//           target_lat - desired total alignment latency
//           latency    - measured latency, saturated at MAX_LAT
//           pad        - target_lat - latency, clamped at 0
//           timeout    - marker not seen within MAX_LAT cycles
module xlatency_probe
   import xlatency_probe_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter int          MAX_LAT = 64,
   parameter logic [31:0] MARKER  = XLP_MARKER_DEFAULT,
   parameter int          CNT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              done,
   output logic [DATA_W-1:0] probe_out,
   input  logic [DATA_W-1:0] probe_in,
   input  logic [CNT_W-1:0]  target_lat,
   output logic [CNT_W-1:0]  latency,
   output logic [CNT_W-1:0]  pad,
   output logic              timeout
);

   localparam logic [DATA_W-1:0] MARKER_W = MARKER[DATA_W-1:0];
   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_LAT);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                done_q;
   logic [DATA_W-1:0]   probe_q;
   logic [CNT_W-1:0]    lat_q;
   logic [CNT_W-1:0]    pad_q;
   logic                timeout_q;

   logic                hit_d;
   logic [CNT_W-1:0]    lat_d;
   logic [CNT_W-1:0]    pad_d;

   // Latency candidate for this cycle: SEND is count 0, WAIT uses the count,
   // and a no-match WAIT at MAX_LAT is exactly MAX_LAT as well.
   always_comb begin
      hit_d = (probe_in == MARKER_W);
      lat_d = (state_q == ST_SEND) ? '0 : cnt_q;
      pad_d = CNT_W'(pad_calc(32'(target_lat), 32'(lat_d)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         done_q    <= 1'b1;
         probe_q   <= '0;
         lat_q     <= '0;
         pad_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (run) begin
                  // Previous result stays visible until the new capture.
                  state_q <= ST_SEND;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  probe_q <= MARKER_W;
               end
            end
            ST_SEND: begin
               probe_q <= '0;
               if (hit_d) begin
                  state_q   <= ST_DONE;
                  done_q    <= 1'b1;
                  lat_q     <= lat_d;
                  pad_q     <= pad_d;
                  timeout_q <= 1'b0;
               end else begin
                  state_q <= ST_WAIT;
                  cnt_q   <= CNT_W'(1);
               end
            end
            ST_WAIT: begin
               // A match on the final cycle still counts as success.
               if (hit_d) begin
                  state_q   <= ST_DONE;
                  done_q    <= 1'b1;
                  lat_q     <= lat_d;
                  pad_q     <= pad_d;
                  timeout_q <= 1'b0;
               end else if (cnt_q == MAX_CNT) begin
                  state_q   <= ST_DONE;
                  done_q    <= 1'b1;
                  lat_q     <= MAX_CNT;
                  pad_q     <= pad_d;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
               probe_q <= '0;
            end
         endcase
      end
   end

   assign done      = done_q;
   assign probe_out = probe_q;
   assign latency   = lat_q;
   assign pad       = pad_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_xlatency_probe.sv
// tb/tb_xlatency_probe.sv - self-checking bench for xlatency_probe
module tb_xlatency_probe;

   localparam int DATA_W  = 32;
   localparam int MAX_LAT = 64;
   localparam int CNT_W   = 7;
   localparam logic [31:0] MARK = 32'hA5A5_5A5A;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run = 1'b0;
   logic              done;
   logic [DATA_W-1:0] probe_out;
   logic [DATA_W-1:0] probe_in;
   logic [CNT_W-1:0]  target_lat = '0;
   logic [CNT_W-1:0]  latency;
   logic [CNT_W-1:0]  pad;
   logic              timeout;

   int checks   = 0;
   int failures = 0;
   int prev_lat = 0;

   // Path under test: a plain delay line of path_dly registers, or open.
   int          path_dly  = 0;
   bit          path_open = 1'b0;
   logic [31:0] hist [0:127];

   always @(posedge clk) begin
      hist[0] <= probe_out;
      for (int i = 1; i < 128; i++) hist[i] <= hist[i-1];
   end

   assign probe_in = path_open ? '0 : ((path_dly == 0) ? probe_out : hist[path_dly-1]);

   always #5 clk = ~clk;

   xlatency_probe #(
      .DATA_W (DATA_W),
      .MAX_LAT(MAX_LAT),
      .MARKER (MARK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .done      (done),
      .probe_out (probe_out),
      .probe_in  (probe_in),
      .target_lat(target_lat),
      .latency   (latency),
      .pad       (pad),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One measurement. Expected result comes from the path description only.
   task automatic measure(input int dly, input bit open, input int tgt,
                          input bit pulse_mid, input bit b2b);
      int exp_lat;
      int exp_to;
      int exp_pad;
      int low;
      if (open || dly > MAX_LAT) begin
         exp_lat = MAX_LAT;
         exp_to  = 1;
      end else begin
         exp_lat = dly;
         exp_to  = 0;
      end
      exp_pad = (tgt > exp_lat) ? tgt - exp_lat : 0;

      if (!b2b) repeat (80) @(negedge clk);
      path_dly   = dly;
      path_open  = open;
      target_lat = CNT_W'($urandom_range(0, 127));
      run        = 1'b1;
      @(negedge clk);
      run        = 1'b0;
      // target_lat only matters at the capture edge, which is still ahead.
      target_lat = CNT_W'(tgt);
      chk("send_done_low", 64'(done), 64'(0));
      chk("send_marker", 64'(probe_out), 64'(MARK));
      chk("old_latency_held", 64'(latency), 64'(prev_lat));

      low = 1;
      while (done === 1'b0 && low < 200) begin
         run = (pulse_mid && low == 3);
         @(negedge clk);
         if (done === 1'b0) low++;
      end
      run = 1'b0;
      chk("done_low_cycles", 64'(low), 64'(exp_lat + 1));
      chk("done_high", 64'(done), 64'(1));
      chk("latency", 64'(latency), 64'(exp_lat));
      chk("pad", 64'(pad), 64'(exp_pad));
      chk("timeout", 64'(timeout), 64'(exp_to));
      chk("probe_out_idle", 64'(probe_out), 64'(0));
      prev_lat = exp_lat;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_done", 64'(done), 64'(1));
      chk("rst_probe_out", 64'(probe_out), 64'(0));
      chk("rst_latency", 64'(latency), 64'(0));
      chk("rst_pad", 64'(pad), 64'(0));
      chk("rst_timeout", 64'(timeout), 64'(0));
      rst = 1'b0;

      measure(3, 1'b0, 5, 1'b0, 1'b0);
      measure(3, 1'b0, 9, 1'b0, 1'b1);
      measure(0, 1'b0, 0, 1'b0, 1'b0);
      measure(0, 1'b1, 70, 1'b0, 1'b0);
      measure(64, 1'b0, 64, 1'b0, 1'b0);
      measure(65, 1'b0, 3, 1'b0, 1'b0);
      measure(10, 1'b0, 4, 1'b1, 1'b0);

      // Reset in WAIT at count 7 on a 20-deep path.
      repeat (80) @(negedge clk);
      path_dly  = 20;
      path_open = 1'b0;
      run       = 1'b1;
      @(negedge clk);
      run = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_measuring", 64'(done), 64'(0));
      rst = 1'b1;
      #1;
      chk("mid_rst_done", 64'(done), 64'(1));
      chk("mid_rst_probe_out", 64'(probe_out), 64'(0));
      chk("mid_rst_latency", 64'(latency), 64'(0));
      chk("mid_rst_pad", 64'(pad), 64'(0));
      chk("mid_rst_timeout", 64'(timeout), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      prev_lat = 0;
      measure(2, 1'b0, 7, 1'b0, 1'b0);

      for (int n = 0; n < 10; n++) begin
         measure(int'($urandom_range(0, 70)), ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 127)), 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
